// File: rtl/screen_fetch.sv
// screen_fetch: prefetches 1-bpp screen words from the shared RAM over a req/gnt
// read port and turns the vga scan position into a registered colour word.
module screen_fetch #(
  parameter int                   RAM_WIDTH         = 16,
  parameter int                   ADDR_WIDTH        = 15,
  parameter int                   RAM_SCREEN_OFFSET = 16384,
  parameter int                   X_OFFSET          = 64,
  parameter int                   Y_OFFSET          = 112,
  parameter int                   PREFETCH_X        = 0,
  parameter int                   RDATA_LATENCY     = 1,
  parameter logic [RAM_WIDTH-1:0] FG_COLOR          = 16'h0000,
  parameter logic [RAM_WIDTH-1:0] BG_COLOR          = 16'h00FF,
  parameter logic [RAM_WIDTH-1:0] BORDER_COLOR      = 16'h0000
) (
  input  logic                  CLK_50,
  input  logic                  RESET_N,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic [RAM_WIDTH-1:0]  mem_rdata,
  output logic [RAM_WIDTH-1:0]  pixel_value,
  output logic                  underrun
);

  localparam int LAT_W = (RDATA_LATENCY < 2) ? 1 : $clog2(RDATA_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [7:0] row, input logic [4:0] col);
    word_addr = ADDR_WIDTH'(RAM_SCREEN_OFFSET) + ADDR_WIDTH'({row, col});
  endfunction

  fetch_state_t state_r, state_nxt_s;
  logic                  mem_req_r, mem_req_nxt_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_nxt_s;
  logic [LAT_W-1:0]      lat_cnt_r, lat_cnt_nxt_s;

  logic [9:0] lx_s, ly_s;
  logic       x_in_s, y_in_s, in_win_s;
  logic [4:0] col_s;
  logic [3:0] bit_s;
  logic [7:0] row_s;
  logic       ls_cond_s, ls_evt_s, ls_prev_r;

  logic [RAM_WIDTH-1:0] cur_word_r, nxt_word_r;
  logic [4:0]           cur_col_r, nxt_col_r;
  logic                 cur_valid_r, nxt_valid_r;
  logic                 hit_cur_s, hit_nxt_s, promote_s, miss_s, queue_next_s;

  logic       q_pend_r, req_avail_s, issue_s, capture_s, capture_ok_s;
  logic [4:0] q_col_r, req_col_s, f_col_r;
  logic [7:0] fetch_row_r, req_row_s;
  logic       gen_r, f_tag_r;

  logic [RAM_WIDTH-1:0] pix_nxt_s, pixel_value_r;
  logic                 underrun_r;

  assign lx_s      = pixel_x - 10'(X_OFFSET);
  assign ly_s      = pixel_y - 10'(Y_OFFSET);
  assign x_in_s    = (pixel_x >= 10'(X_OFFSET)) && (lx_s[9] == 1'b0);
  assign y_in_s    = (pixel_y >= 10'(Y_OFFSET)) && (ly_s[9:8] == 2'b00);
  assign in_win_s  = x_in_s && y_in_s;
  assign col_s     = lx_s[8:4];
  assign bit_s     = lx_s[3:0];
  assign row_s     = ly_s[7:0];
  // vga holds each column for several cycles; only the first one starts a line
  assign ls_cond_s = (pixel_x == 10'(PREFETCH_X)) && y_in_s;
  assign ls_evt_s  = ls_cond_s && !ls_prev_r;

  assign hit_cur_s    = cur_valid_r && (cur_col_r == col_s);
  assign hit_nxt_s    = !hit_cur_s && nxt_valid_r && (nxt_col_r == col_s);
  assign promote_s    = in_win_s && hit_nxt_s;
  assign miss_s       = in_win_s && !hit_cur_s && !hit_nxt_s;
  assign queue_next_s = promote_s && (col_s != 5'd31);

  // Fetch source: a line start overrides any queued column
  always_comb begin
    req_avail_s = ls_evt_s || queue_next_s || q_pend_r;
    req_col_s   = q_col_r;
    req_row_s   = fetch_row_r;
    if (ls_evt_s) begin
      req_col_s = 5'd0;
      req_row_s = row_s;
    end else if (queue_next_s) begin
      req_col_s = col_s + 5'd1;
      req_row_s = fetch_row_r;
    end else begin
      req_col_s = q_col_r;
      req_row_s = fetch_row_r;
    end
  end

  // Fetch FSM next state and registered port values
  always_comb begin
    state_nxt_s    = state_r;
    mem_req_nxt_s  = mem_req_r;
    mem_addr_nxt_s = mem_addr_r;
    lat_cnt_nxt_s  = lat_cnt_r;
    issue_s        = 1'b0;
    capture_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_avail_s) begin
          issue_s        = 1'b1;
          mem_req_nxt_s  = 1'b1;
          mem_addr_nxt_s = word_addr(req_row_s, req_col_s);
          state_nxt_s    = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          mem_req_nxt_s = 1'b0;
          lat_cnt_nxt_s = LAT_W'(1);
          state_nxt_s   = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_r == LAT_W'(RDATA_LATENCY)) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          lat_cnt_nxt_s = lat_cnt_r + LAT_W'(1);
          state_nxt_s   = ST_WAIT;
        end
      end
      default: begin
        mem_req_nxt_s = 1'b0;
        state_nxt_s   = ST_IDLE;
      end
    endcase
  end

  // Data from a fetch issued before the latest line start is stale
  assign capture_ok_s = capture_s && (f_tag_r == gen_r) && !ls_evt_s;

  // Colour for the current scan position
  always_comb begin
    pix_nxt_s = BORDER_COLOR;
    if (!in_win_s) begin
      pix_nxt_s = BORDER_COLOR;
    end else if (hit_cur_s) begin
      pix_nxt_s = cur_word_r[bit_s] ? FG_COLOR : BG_COLOR;
    end else if (hit_nxt_s) begin
      pix_nxt_s = nxt_word_r[bit_s] ? FG_COLOR : BG_COLOR;
    end else begin
      pix_nxt_s = BG_COLOR;
    end
  end

  // Fetch FSM state and memory port registers
  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      state_r    <= ST_IDLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= {ADDR_WIDTH{1'b0}};
      lat_cnt_r  <= {LAT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      mem_req_r  <= mem_req_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
      lat_cnt_r  <= lat_cnt_nxt_s;
    end
  end

  // Word buffer, fetch queue, pixel output and underrun flag
  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      ls_prev_r     <= 1'b0;
      gen_r         <= 1'b0;
      fetch_row_r   <= 8'd0;
      cur_word_r    <= {RAM_WIDTH{1'b0}};
      nxt_word_r    <= {RAM_WIDTH{1'b0}};
      cur_col_r     <= 5'd0;
      nxt_col_r     <= 5'd0;
      cur_valid_r   <= 1'b0;
      nxt_valid_r   <= 1'b0;
      q_pend_r      <= 1'b0;
      q_col_r       <= 5'd0;
      f_col_r       <= 5'd0;
      f_tag_r       <= 1'b0;
      pixel_value_r <= {RAM_WIDTH{1'b0}};
      underrun_r    <= 1'b0;
    end else begin
      ls_prev_r <= ls_cond_s;
      if (ls_evt_s) begin
        gen_r       <= ~gen_r;
        fetch_row_r <= row_s;
        cur_valid_r <= 1'b0;
        nxt_valid_r <= 1'b0;
      end else begin
        if (promote_s) begin
          cur_word_r  <= nxt_word_r;
          cur_col_r   <= nxt_col_r;
          cur_valid_r <= 1'b1;
          nxt_valid_r <= 1'b0;
        end
        // a capture in the same cycle refills nxt after the promote consumed it
        if (capture_ok_s) begin
          nxt_word_r  <= mem_rdata;
          nxt_col_r   <= f_col_r;
          nxt_valid_r <= 1'b1;
        end
      end
      if (issue_s) begin
        f_col_r <= req_col_s;
        f_tag_r <= gen_r ^ ls_evt_s;
      end
      q_pend_r      <= req_avail_s && !issue_s;
      q_col_r       <= req_col_s;
      pixel_value_r <= pix_nxt_s;
      if (miss_s) begin
        underrun_r <= 1'b1;
      end
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign pixel_value = pixel_value_r;
  assign underrun    = underrun_r;

endmodule
